// File: rtl/pulse_mon_pkg.sv
// Shared types, widths, error codes and saturating arithmetic helpers
// for the TTL pulse-train monitor.
package pulse_mon_pkg;

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned PCNT_W = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FIRST = 3'd1,
    HIGH       = 3'd2,
    LOW        = 3'd3,
    DONE       = 3'd4,
    ERR        = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_WIDTH  = 2'd1;
  localparam logic [1:0] ERR_PERIOD = 2'd2;
  localparam logic [1:0] ERR_START  = 2'd3;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[CNT_W] ? '0 : d[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

  function automatic logic [PCNT_W-1:0] sat_inc16(input logic [PCNT_W-1:0] a);
    return (a == '1) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/ttl_edge_sync.sv
// Multi-flop synchronizer for an asynchronous TTL line, followed by a
// one-flop edge detector producing single-cycle rise/fall strobes.
module ttl_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/pulse_train_monitor.sv
// Measures high time, period and pulse count of one TTL line and checks
// them against an expected train latched on arm; reports done or error.
module pulse_train_monitor
  import pulse_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [31:0] TOL           = 32'd0,
  parameter logic [31:0] START_TIMEOUT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ttl_in,
  input  logic        arm,
  input  logic [31:0] exp_width,
  input  logic [31:0] exp_period,
  input  logic [15:0] exp_count,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] meas_width,
  output logic [31:0] meas_period,
  output logic [15:0] meas_count
);

  logic rise, fall;

  ttl_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ttl_in),
    .rise  (rise),
    .fall  (fall)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    exp_width_q, exp_width_d;
  logic [CNT_W-1:0]    exp_period_q, exp_period_d;
  logic [PCNT_W-1:0]   exp_count_q, exp_count_d;
  logic [CNT_W-1:0]    width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]    start_cnt_q, start_cnt_d;
  logic [CNT_W-1:0]    meas_width_q, meas_width_d;
  logic [CNT_W-1:0]    meas_period_q, meas_period_d;
  logic [PCNT_W-1:0]   meas_count_q, meas_count_d;
  logic [1:0]          err_code_q, err_code_d;

  logic [CNT_W-1:0] w_lo, w_hi, w_lim, p_lo, p_hi, p_lim;
  logic             width_ok, period_ok;

  // Acceptance windows saturate at 0 / all-ones; *_lim is the first
  // count that can no longer end in a valid pulse or period.
  always_comb begin
    w_lo      = sat_sub(exp_width_q, TOL);
    w_hi      = sat_add(exp_width_q, TOL);
    w_lim     = sat_inc(w_hi);
    p_lo      = sat_sub(exp_period_q, TOL);
    p_hi      = sat_add(exp_period_q, TOL);
    p_lim     = sat_inc(p_hi);
    width_ok  = (width_cnt_q >= w_lo) && (width_cnt_q <= w_hi);
    period_ok = (period_cnt_q >= p_lo) && (period_cnt_q <= p_hi);
  end

  always_comb begin
    state_d       = state_q;
    exp_width_d   = exp_width_q;
    exp_period_d  = exp_period_q;
    exp_count_d   = exp_count_q;
    width_cnt_d   = width_cnt_q;
    period_cnt_d  = period_cnt_q;
    start_cnt_d   = start_cnt_q;
    meas_width_d  = meas_width_q;
    meas_period_d = meas_period_q;
    meas_count_d  = meas_count_q;
    err_code_d    = err_code_q;

    if (arm) begin
      exp_width_d   = exp_width;
      exp_period_d  = exp_period;
      exp_count_d   = exp_count;
      width_cnt_d   = '0;
      period_cnt_d  = '0;
      start_cnt_d   = '0;
      meas_width_d  = '0;
      meas_period_d = '0;
      meas_count_d  = '0;
      err_code_d    = ERR_NONE;
      state_d       = (exp_count == '0) ? DONE : WAIT_FIRST;
    end else begin
      unique case (state_q)
        WAIT_FIRST: begin
          if (rise) begin
            meas_count_d = 16'd1;
            width_cnt_d  = 32'd1;
            period_cnt_d = 32'd1;
            state_d      = HIGH;
          end else begin
            start_cnt_d = sat_inc(start_cnt_q);
            if ((START_TIMEOUT != '1) && (start_cnt_d == START_TIMEOUT)) begin
              err_code_d = ERR_START;
              state_d    = ERR;
            end
          end
        end
        HIGH: begin
          period_cnt_d = sat_inc(period_cnt_q);
          if (fall) begin
            meas_width_d = width_cnt_q;
            if (!width_ok) begin
              err_code_d = ERR_WIDTH;
              state_d    = ERR;
            end else if (meas_count_q == exp_count_q) begin
              state_d = DONE;
            end else begin
              state_d = LOW;
            end
          end else begin
            width_cnt_d = sat_inc(width_cnt_q);
            if (width_cnt_d >= w_lim) begin
              meas_width_d = width_cnt_d;
              err_code_d   = ERR_WIDTH;
              state_d      = ERR;
            end
          end
        end
        LOW: begin
          period_cnt_d = sat_inc(period_cnt_q);
          if (rise) begin
            meas_period_d = period_cnt_q;
            if (!period_ok) begin
              err_code_d = ERR_PERIOD;
              state_d    = ERR;
            end else begin
              meas_count_d = sat_inc16(meas_count_q);
              width_cnt_d  = 32'd1;
              period_cnt_d = 32'd1;
              state_d      = HIGH;
            end
          end else if (period_cnt_d >= p_lim) begin
            err_code_d = ERR_PERIOD;
            state_d    = ERR;
          end
        end
        IDLE, DONE, ERR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      exp_width_q   <= '0;
      exp_period_q  <= '0;
      exp_count_q   <= '0;
      width_cnt_q   <= '0;
      period_cnt_q  <= '0;
      start_cnt_q   <= '0;
      meas_width_q  <= '0;
      meas_period_q <= '0;
      meas_count_q  <= '0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      exp_width_q   <= exp_width_d;
      exp_period_q  <= exp_period_d;
      exp_count_q   <= exp_count_d;
      width_cnt_q   <= width_cnt_d;
      period_cnt_q  <= period_cnt_d;
      start_cnt_q   <= start_cnt_d;
      meas_width_q  <= meas_width_d;
      meas_period_q <= meas_period_d;
      meas_count_q  <= meas_count_d;
      err_code_q    <= err_code_d;
    end
  end

  assign busy        = (state_q == WAIT_FIRST) || (state_q == HIGH) || (state_q == LOW);
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERR);
  assign err_code    = err_code_q;
  assign meas_width  = meas_width_q;
  assign meas_period = meas_period_q;
  assign meas_count  = meas_count_q;

endmodule

// File: tb/tb_pulse_train_monitor.sv
// Directed bench: three monitor instances (TOL 0/1/2, first one with a
// 50-cycle start timeout) watch the same line; table vectors plus corner sequences.
module tb_pulse_train_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ttl_in;
  logic        arm;
  logic [31:0] exp_width;
  logic [31:0] exp_period;
  logic [15:0] exp_count;

  logic        busy [3];
  logic        done [3];
  logic        error [3];
  logic [1:0]  err_code [3];
  logic [31:0] meas_width [3];
  logic [31:0] meas_period [3];
  logic [15:0] meas_count [3];

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  always #5 clk = ~clk;

  pulse_train_monitor #(.SYNC_STAGES(2), .TOL(32'd0), .START_TIMEOUT(32'd50)) u0 (
    .clk(clk), .rst_n(rst_n), .ttl_in(ttl_in), .arm(arm),
    .exp_width(exp_width), .exp_period(exp_period), .exp_count(exp_count),
    .busy(busy[0]), .done(done[0]), .error(error[0]), .err_code(err_code[0]),
    .meas_width(meas_width[0]), .meas_period(meas_period[0]), .meas_count(meas_count[0]));

  pulse_train_monitor #(.SYNC_STAGES(2), .TOL(32'd1)) u1 (
    .clk(clk), .rst_n(rst_n), .ttl_in(ttl_in), .arm(arm),
    .exp_width(exp_width), .exp_period(exp_period), .exp_count(exp_count),
    .busy(busy[1]), .done(done[1]), .error(error[1]), .err_code(err_code[1]),
    .meas_width(meas_width[1]), .meas_period(meas_period[1]), .meas_count(meas_count[1]));

  pulse_train_monitor #(.SYNC_STAGES(2), .TOL(32'd2)) u2 (
    .clk(clk), .rst_n(rst_n), .ttl_in(ttl_in), .arm(arm),
    .exp_width(exp_width), .exp_period(exp_period), .exp_count(exp_count),
    .busy(busy[2]), .done(done[2]), .error(error[2]), .err_code(err_code[2]),
    .meas_width(meas_width[2]), .meas_period(meas_period[2]), .meas_count(meas_count[2]));

  typedef struct packed {
    logic        done;
    logic [1:0]  code;
    logic [15:0] mc;
    logic [31:0] mw;
    logic [31:0] mp;
  } res_t;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] p;
    logic [15:0] c;
    logic [7:0]  bi;
    logic [31:0] bw;
    logic [31:0] bp;
    res_t [2:0]  r;
  } vec_t;

  localparam int NVEC = 6;
  vec_t tbl [NVEC];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else
      n_pass++;
  endtask

  // Later changes to exp_* must be ignored, so they are scrambled after arm.
  task automatic arm_dut(input logic [31:0] w, input logic [31:0] p, input logic [15:0] c);
    exp_width  = w;
    exp_period = p;
    exp_count  = c;
    arm        = 1'b1;
    step();
    arm        = 1'b0;
    exp_width  = $urandom;
    exp_period = $urandom;
    exp_count  = 16'($urandom);
  endtask

  task automatic run_train(input logic [31:0] w, input logic [31:0] p, input int n,
                           input int bi, input logic [31:0] bw, input logic [31:0] bp);
    logic [31:0] hw, pp;
    for (int i = 0; i < n; i++) begin
      hw = (i == bi) ? bw : w;
      pp = (i == bi) ? bp : p;
      ttl_in = 1'b1;
      repeat (hw) step();
      ttl_in = 1'b0;
      repeat (pp - hw) step();
    end
  endtask

  task automatic chk_zero(input string tag, input int k);
    chk($sformatf("%s.busy", tag), 32'(busy[k]), 32'd0);
    chk($sformatf("%s.done", tag), 32'(done[k]), 32'd0);
    chk($sformatf("%s.error", tag), 32'(error[k]), 32'd0);
    chk($sformatf("%s.err_code", tag), 32'(err_code[k]), 32'd0);
    chk($sformatf("%s.meas_width", tag), meas_width[k], 32'd0);
    chk($sformatf("%s.meas_period", tag), meas_period[k], 32'd0);
    chk($sformatf("%s.meas_count", tag), 32'(meas_count[k]), 32'd0);
  endtask

  function automatic res_t R(input logic d, input logic [1:0] code, input logic [15:0] mc,
                             input logic [31:0] mw, input logic [31:0] mp);
    return '{done: d, code: code, mc: mc, mw: mw, mp: mp};
  endfunction

  initial begin
    // Fields: w, p, c, bad index, bad width, bad period, expected {u2, u1, u0}.
    tbl[0] = '{w: 100, p: 1000, c: 10, bi: 8'hFF, bw: 0, bp: 0,
               r: {R(1, 0, 10, 100, 1000), R(1, 0, 10, 100, 1000), R(1, 0, 10, 100, 1000)}};
    tbl[1] = '{w: 100, p: 1000, c: 10, bi: 2, bw: 101, bp: 1000,
               r: {R(1, 0, 10, 100, 1000), R(1, 0, 10, 100, 1000), R(0, 1, 3, 101, 1000)}};
    tbl[2] = '{w: 5, p: 12, c: 4, bi: 1, bw: 4, bp: 12,
               r: {R(1, 0, 4, 5, 12), R(1, 0, 4, 5, 12), R(0, 1, 2, 4, 12)}};
    tbl[3] = '{w: 1, p: 3, c: 3, bi: 8'hFF, bw: 0, bp: 0,
               r: {R(1, 0, 3, 1, 3), R(1, 0, 3, 1, 3), R(1, 0, 3, 1, 3)}};
    tbl[4] = '{w: 5, p: 20, c: 4, bi: 1, bw: 5, bp: 18,
               r: {R(1, 0, 4, 5, 20), R(0, 2, 2, 5, 18), R(0, 2, 2, 5, 18)}};
    tbl[5] = '{w: 5, p: 20, c: 4, bi: 1, bw: 5, bp: 22,
               r: {R(1, 0, 4, 5, 20), R(0, 2, 2, 5, 20), R(0, 2, 2, 5, 20)}};

    rst_n = 1'b0; ttl_in = 1'b0; arm = 1'b0;
    exp_width = '0; exp_period = '0; exp_count = '0;
    repeat (3) step();
    chk_zero("reset.u0", 0);
    rst_n = 1'b1;
    repeat (2) step();

    for (int v = 0; v < NVEC; v++) begin
      arm_dut(tbl[v].w, tbl[v].p, tbl[v].c);
      run_train(tbl[v].w, tbl[v].p, int'(tbl[v].c),
                (tbl[v].bi == 8'hFF) ? -1 : int'(tbl[v].bi), tbl[v].bw, tbl[v].bp);
      repeat (8) step();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("v%0d.u%0d.done", v, k), 32'(done[k]), 32'(tbl[v].r[k].done));
        chk($sformatf("v%0d.u%0d.error", v, k), 32'(error[k]), 32'(tbl[v].r[k].code != 2'd0));
        chk($sformatf("v%0d.u%0d.err_code", v, k), 32'(err_code[k]), 32'(tbl[v].r[k].code));
        chk($sformatf("v%0d.u%0d.meas_count", v, k), 32'(meas_count[k]), 32'(tbl[v].r[k].mc));
        chk($sformatf("v%0d.u%0d.meas_width", v, k), meas_width[k], tbl[v].r[k].mw);
        chk($sformatf("v%0d.u%0d.meas_period", v, k), meas_period[k], tbl[v].r[k].mp);
        chk($sformatf("v%0d.u%0d.busy", v, k), 32'(busy[k]), 32'd0);
      end
    end

    // Line already high at arm: no pulse; u0 times out on cycle 50, u1 keeps waiting.
    ttl_in = 1'b1;
    repeat (5) step();
    arm_dut(100, 1000, 10);
    repeat (49) step();
    chk("tmo.u0.error@50", 32'(error[0]), 32'd0);
    step();
    chk("tmo.u0.error@51", 32'(error[0]), 32'd1);
    chk("tmo.u0.err_code", 32'(err_code[0]), 32'd3);
    chk("tmo.u0.meas_count", 32'(meas_count[0]), 32'd0);
    chk("tmo.u1.busy", 32'(busy[1]), 32'd1);
    chk("tmo.u1.meas_count", 32'(meas_count[1]), 32'd0);
    ttl_in = 1'b0;
    repeat (5) step();

    // Train stops after 5 pulses: missing-pulse error at period count exp+TOL+1.
    arm_dut(100, 1000, 10);
    run_train(100, 1000, 4, -1, 0, 0);
    ttl_in = 1'b1;
    for (int k = 1; k <= 1005; k++) begin
      step();
      if (k == 100) ttl_in = 1'b0;
      if (k == 1002) chk("miss.u0.error_early", 32'(error[0]), 32'd0);
      if (k == 1003) begin
        chk("miss.u0.error", 32'(error[0]), 32'd1);
        chk("miss.u0.err_code", 32'(err_code[0]), 32'd2);
        chk("miss.u0.meas_count", 32'(meas_count[0]), 32'd5);
        chk("miss.u0.busy", 32'(busy[0]), 32'd0);
      end
      if (k == 1004) chk("miss.u2.error_early", 32'(error[2]), 32'd0);
      if (k == 1005) chk("miss.u2.err_code", 32'(err_code[2]), 32'd2);
    end

    // Stuck high: width error as the count reaches exp_width+TOL+1.
    arm_dut(100, 1000, 10);
    ttl_in = 1'b1;
    for (int k = 1; k <= 105; k++) begin
      step();
      if (k == 102) chk("stuck.u0.error_early", 32'(error[0]), 32'd0);
      if (k == 103) begin
        chk("stuck.u0.err_code", 32'(err_code[0]), 32'd1);
        chk("stuck.u0.meas_width", meas_width[0], 32'd101);
      end
      if (k == 104) chk("stuck.u2.error_early", 32'(error[2]), 32'd0);
      if (k == 105) begin
        chk("stuck.u2.err_code", 32'(err_code[2]), 32'd1);
        chk("stuck.u2.meas_width", meas_width[2], 32'd103);
      end
    end
    ttl_in = 1'b0;
    repeat (5) step();

    // Re-arm while the line is high: the stale pulse is not counted.
    arm_dut(5, 12, 4);
    run_train(5, 12, 1, -1, 0, 0);
    ttl_in = 1'b1;
    repeat (3) step();
    arm_dut(5, 12, 4);
    chk("rearm.u0.meas_count", 32'(meas_count[0]), 32'd0);
    chk("rearm.u0.busy", 32'(busy[0]), 32'd1);
    repeat (2) step();
    ttl_in = 1'b0;
    repeat (8) step();
    chk("rearm.u0.stale_count", 32'(meas_count[0]), 32'd0);
    run_train(5, 12, 4, -1, 0, 0);
    repeat (4) step();
    chk("rearm.u0.done", 32'(done[0]), 32'd1);
    chk("rearm.u0.meas_count", 32'(meas_count[0]), 32'd4);
    chk("rearm.u0.meas_period", meas_period[0], 32'd12);

    // Asynchronous reset mid-HIGH, sampled before the next clock edge.
    arm_dut(100, 1000, 10);
    ttl_in = 1'b1;
    repeat (10) step();
    chk("rst.u0.busy_before", 32'(busy[0]), 32'd1);
    chk("rst.u0.count_before", 32'(meas_count[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst.u0", 0);
    ttl_in = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) step();

    // exp_count == 0 completes one cycle after arm.
    arm_dut(100, 1000, 0);
    chk("zero.u0.done", 32'(done[0]), 32'd1);
    chk("zero.u0.busy", 32'(busy[0]), 32'd0);
    chk("zero.u0.error", 32'(error[0]), 32'd0);
    chk("zero.u0.meas_count", 32'(meas_count[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
